// File: rtl/hdlc_rx_reader_pkg.sv
// rtl/hdlc_rx_reader_pkg.sv - shared types and Rx_SC constants for the Hdlc receive drain engine
package hdlc_rx_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SC_WAIT,
    ST_LEN_WAIT,
    ST_RD,
    ST_RD_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_FRAME    = 3'd1,
    ERR_ABORT    = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_BAD_LEN  = 3'd4
  } err_code_t;

  // Rx_SC register bit positions
  localparam int RX_SC_READY    = 0;
  localparam int RX_SC_DROP     = 1;
  localparam int RX_SC_FRAMEERR = 2;
  localparam int RX_SC_ABORT    = 3;
  localparam int RX_SC_OVERFLOW = 4;
  localparam int RX_SC_FCSEN    = 5;

  // Writing this to Rx_SC discards the frame held in the Hdlc
  localparam logic [7:0] RX_DROP_CMD = 8'(1 << RX_SC_DROP);

  // A frame length is usable when it is non-zero and fits the buffer
  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/hdlc_rx_reader_bus_master.sv
// rtl/hdlc_rx_reader_bus_master.sv - Hdlc register strobe sequencer and read-data capture
module hdlc_bus_master (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [2:0] Address,
  output logic       ReadEnable,
  output logic       WriteEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  output logic [7:0] rdata,
  output logic       rdata_valid
);

  // Requests arrive as registered one-cycle pulses; a write wins so the strobes never overlap
  assign WriteEnable = wr_req;
  assign ReadEnable  = rd_req & ~wr_req;
  assign Address     = (rd_req | wr_req) ? req_addr : 3'd0;
  assign DataIn      = wr_req ? req_wdata : 8'd0;
  assign rdata       = DataOut;

  // Read data from the Hdlc is valid exactly one cycle after the read strobe
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= ReadEnable;
    end
  end

endmodule

// File: rtl/hdlc_rx_reader.sv
// rtl/hdlc_rx_reader.sv - Hdlc Rx drain engine to byte stream; HDLC_RX_READER_STATS_EN adds frame/error counters
module hdlc_rx_reader
  import hdlc_rx_reader_pkg::*;
#(
  parameter logic [2:0]  ADDR_RX_SC   = 3'h2,
  parameter logic [2:0]  ADDR_RX_BUFF = 3'h3,
  parameter logic [2:0]  ADDR_RX_LEN  = 3'h4,
  parameter int unsigned MAX_LEN      = 126
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        en,
  input  logic        Rx_Ready,
  output logic [2:0]  Address,
  output logic        ReadEnable,
  output logic        WriteEnable,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        err_pulse,
  output logic [2:0]  err_code,
  output logic        busy
`ifdef HDLC_RX_READER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  state_t     state;
  logic       rd_req;
  logic       wr_req;
  logic [2:0] req_addr;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic [6:0] len;
  logic [6:0] cnt;

  hdlc_bus_master u_bus (
    .Clk         (Clk),
    .Rst         (Rst),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .req_addr    (req_addr),
    .req_wdata   (RX_DROP_CMD),
    .Address     (Address),
    .ReadEnable  (ReadEnable),
    .WriteEnable (WriteEnable),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .rdata       (rdata),
    .rdata_valid (rdata_valid)
  );

  assign busy = (state != ST_IDLE);

  // Frame drain sequence: status, length, then one buffer read per streamed byte
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      req_addr  <= 3'd0;
      len       <= 7'd0;
      cnt       <= 7'd0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && Rx_Ready) begin
            rd_req   <= 1'b1;
            req_addr <= ADDR_RX_SC;
            state    <= ST_SC_WAIT;
          end
        end
        ST_SC_WAIT: begin
          if (rdata_valid) begin
            if (rdata[RX_SC_FRAMEERR]) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_FRAME;
              state     <= ST_DONE;
            end else if (rdata[RX_SC_ABORT]) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_ABORT;
              state     <= ST_DONE;
            end else if (rdata[RX_SC_OVERFLOW]) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_OVERFLOW;
              state     <= ST_DONE;
            end else begin
              rd_req   <= 1'b1;
              req_addr <= ADDR_RX_LEN;
              state    <= ST_LEN_WAIT;
            end
          end
        end
        ST_LEN_WAIT: begin
          if (rdata_valid) begin
            len <= rdata[6:0];
            if (!len_ok(rdata, 8'(MAX_LEN))) begin
              // Unusable length: discard the frame in the Hdlc so Rx_Ready can fall
              err_pulse <= 1'b1;
              err_code  <= ERR_BAD_LEN;
              wr_req    <= 1'b1;
              req_addr  <= ADDR_RX_SC;
              state     <= ST_DONE;
            end else begin
              // The buffer read strobe is raised while the FSM sits in RD
              cnt      <= 7'd0;
              rd_req   <= 1'b1;
              req_addr <= ADDR_RX_BUFF;
              state    <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rdata_valid) begin
            m_data  <= rdata;
            m_valid <= 1'b1;
            m_last  <= (cnt == len - 7'd1);
            state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              cnt   <= 7'd0;
              state <= ST_DONE;
            end else begin
              cnt      <= cnt + 7'd1;
              rd_req   <= 1'b1;
              req_addr <= ADDR_RX_BUFF;
              state    <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HDLC_RX_READER_STATS_EN
  // Saturating counts of completed frames and rejected frames
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (state == ST_OUT && m_valid && m_ready && m_last && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err_pulse && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdlc_rx_reader.sv
// tb/tb_hdlc_rx_reader.sv - self-checking bench for hdlc_rx_reader with an Hdlc register model
module tb_hdlc_rx_reader;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       en = 1'b0;
  logic       Rx_Ready = 1'b0;
  logic [2:0] Address;
  logic       ReadEnable;
  logic       WriteEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut = 8'd0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;
  logic       err_pulse;
  logic [2:0] err_code;
  logic       busy;
`ifdef HDLC_RX_READER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  always #5 Clk = ~Clk;

  hdlc_rx_reader dut (
    .Clk(Clk), .Rst(Rst), .en(en), .Rx_Ready(Rx_Ready),
    .Address(Address), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
    .DataIn(DataIn), .DataOut(DataOut),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
`ifdef HDLC_RX_READER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  // Hdlc register model: answers reads one cycle later and logs all bus activity
  logic [7:0] hs_status;
  logic [7:0] hs_len;
  logic [7:0] hs_buf [256];
  int         buf_base = 0;
  int         n_sc = 0, n_len = 0, n_buff = 0, n_wr = 0, bus_viol = 0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;

  always @(posedge Clk) begin
    if (ReadEnable && WriteEnable) bus_viol <= bus_viol + 1;
    else if (!ReadEnable && !WriteEnable && Address != 3'd0) bus_viol <= bus_viol + 1;
    if (ReadEnable) begin
      case (Address)
        3'd2: begin DataOut <= hs_status; n_sc <= n_sc + 1; end
        3'd4: begin DataOut <= hs_len; n_len <= n_len + 1; end
        3'd3: begin DataOut <= hs_buf[8'(n_buff - buf_base)]; n_buff <= n_buff + 1; end
        default: DataOut <= 8'hEE;
      endcase
    end
    if (WriteEnable) begin
      n_wr    <= n_wr + 1;
      wr_addr <= Address;
      wr_data <= DataIn;
    end
  end

  int errors = 0;
  int checks = 0;
  int exp_hold = 0;
  int exp_frames = 0;
  int exp_errs = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference outcome of one frame from the status byte and length alone
  function automatic int ref_code(input logic [7:0] st, input logic [7:0] ln);
    if (st[2]) return 1;
    if (st[3]) return 2;
    if (st[4]) return 3;
    if (ln == 8'd0 || ln > 8'd126) return 4;
    return 0;
  endfunction

  // stall: 0 ready always (with timing checks), 1 random ready, 2 hold byte 2 for 5 cycles, 3 ready always
  task automatic run_frame(input logic [7:0] st, input logic [7:0] ln, input int stall,
                           input bit drop_en, input int exp_code, input int exp_bytes, input string tag);
    int b_sc, b_len, b_buff, b_wr, b_viol;
    bit seen = 0, done = 0;
    int nacc = 0, npulse = 0, code_seen = -1, stab_viol = 0, stall_left = 5;
    int first_valid = -1, prev_acc = 0, gap_bad = 0;
    bit pv = 0, pr = 0, pl = 0;
    logic [7:0] pd = 8'd0;
    int pnb = 0;
    logic [7:0] got_d[$];
    bit got_l[$];
    @(negedge Clk);
    hs_status = st;
    hs_len    = ln;
    buf_base  = n_buff;
    b_sc = n_sc; b_len = n_len; b_buff = n_buff; b_wr = n_wr; b_viol = bus_viol;
    en = 1'b1;
    Rx_Ready = 1'b1;
    m_ready = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge Clk);
      #1;
      if (busy && !seen) begin
        seen = 1;
        Rx_Ready = 1'b0;
        if (drop_en) en = 1'b0;
      end
      if (pv && !pr) begin
        if (!m_valid || m_data !== pd || m_last !== pl || n_buff != pnb) stab_viol++;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      case (stall)
        0, 3: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = !(m_valid && nacc == 1 && stall_left > 0);
      endcase
      if (stall == 2 && !m_ready) stall_left--;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        if (stall == 0 && nacc > 0 && cyc - prev_acc != 3) gap_bad++;
        prev_acc = cyc;
        nacc++;
      end
      if (err_pulse) begin
        npulse++;
        code_seen = int'(err_code);
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last; pnb = n_buff;
      if (seen && !busy) begin
        done = 1;
        break;
      end
    end
    m_ready = 1'b0;
    en = 1'b1;
    Rx_Ready = 1'b0;
    check({tag, " finished"}, int'(done), 1);
    check({tag, " bytes"}, got_d.size(), exp_bytes);
    for (int k = 0; k < got_d.size() && k < exp_bytes; k++) begin
      check($sformatf("%s data%0d", tag, k), int'(got_d[k]), int'(hs_buf[k]));
      check($sformatf("%s last%0d", tag, k), int'(got_l[k]), int'(k == exp_bytes - 1));
    end
    check({tag, " err_pulses"}, npulse, int'(exp_code != 0));
    if (exp_code != 0) begin
      exp_hold = exp_code;
      check({tag, " err_code at pulse"}, code_seen, exp_code);
      exp_errs++;
    end else begin
      exp_frames++;
    end
    check({tag, " err_code held"}, int'(err_code), exp_hold);
    check({tag, " sc reads"}, n_sc - b_sc, 1);
    check({tag, " len reads"}, n_len - b_len, int'(exp_code == 0 || exp_code == 4));
    check({tag, " buff reads"}, n_buff - b_buff, exp_bytes);
    check({tag, " writes"}, n_wr - b_wr, int'(exp_code == 4));
    if (exp_code == 4) begin
      check({tag, " drop addr"}, int'(wr_addr), 2);
      check({tag, " drop data"}, int'(wr_data), 2);
    end
    check({tag, " stall stability"}, stab_viol, 0);
    check({tag, " bus rules"}, bus_viol - b_viol, 0);
    if (stall == 0 && exp_bytes > 0) begin
      check({tag, " latency"}, first_valid - 1, 6);
      check({tag, " byte spacing"}, gap_bad, 0);
    end
    if (stall == 2) check({tag, " stall cycles"}, 5 - stall_left, 5);
  endtask

  typedef struct {
    logic [7:0] status;
    logic [7:0] len;
    int         stall;
    bit         drop_en;
    int         exp_code;
    int         exp_bytes;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h01, 8'd3,   0, 1'b0, 0, 3};
    vecs[1]  = '{8'h01, 8'd1,   0, 1'b0, 0, 1};
    vecs[2]  = '{8'h01, 8'd126, 1, 1'b0, 0, 126};
    vecs[3]  = '{8'h05, 8'd3,   0, 1'b0, 1, 0};
    vecs[4]  = '{8'h09, 8'd3,   0, 1'b0, 2, 0};
    vecs[5]  = '{8'h11, 8'd3,   0, 1'b0, 3, 0};
    vecs[6]  = '{8'h1D, 8'd3,   0, 1'b0, 1, 0};
    vecs[7]  = '{8'h19, 8'd3,   0, 1'b0, 2, 0};
    vecs[8]  = '{8'h01, 8'd0,   0, 1'b0, 4, 0};
    vecs[9]  = '{8'h01, 8'd127, 0, 1'b0, 4, 0};
    vecs[10] = '{8'h01, 8'd255, 0, 1'b0, 4, 0};
    vecs[11] = '{8'h21, 8'd5,   2, 1'b1, 0, 5};

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("reset m_valid", int'(m_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset err_pulse", int'(err_pulse), 0);
    check("reset err_code", int'(err_code), 0);
    check("reset strobes", int'({ReadEnable, WriteEnable, Address}), 0);
    @(negedge Clk);
    Rst = 1'b1;

    // Engine disabled: Rx_Ready is not acted upon
    begin
      int b = n_sc;
      en = 1'b0;
      Rx_Ready = 1'b1;
      repeat (10) @(posedge Clk);
      #1;
      check("disabled busy", int'(busy), 0);
      check("disabled sc reads", n_sc - b, 0);
      @(negedge Clk);
      Rx_Ready = 1'b0;
      en = 1'b1;
    end

    // Three-byte frame, free-running sink then a stalled second byte
    hs_buf[0] = 8'hA5; hs_buf[1] = 8'h0F; hs_buf[2] = 8'hC3;
    run_frame(8'h01, 8'd3, 0, 1'b0, 0, 3, "good3");
    run_frame(8'h01, 8'd3, 2, 1'b0, 0, 3, "stall3");
    run_frame(8'h09, 8'd3, 0, 1'b0, 2, 0, "abort");
    run_frame(8'h01, 8'd0, 0, 1'b0, 4, 0, "len0");
    run_frame(8'h01, 8'd127, 0, 1'b0, 4, 0, "len127");

    // Reset in the middle of a frame, then the frame is drained again from its status
    begin
      bit acc = 0;
      @(negedge Clk);
      hs_status = 8'h01; hs_len = 8'd3; buf_base = n_buff;
      en = 1'b1; Rx_Ready = 1'b1; m_ready = 1'b1;
      for (int c = 0; c < 50 && !acc; c++) begin
        @(posedge Clk);
        #1;
        if (m_valid && m_ready) acc = 1;
      end
      check("midreset first byte seen", int'(acc), 1);
      @(posedge Clk);
      #3;
      Rst = 1'b0;
      #1;
      check("midreset m_valid", int'(m_valid), 0);
      check("midreset busy", int'(busy), 0);
      check("midreset strobes", int'({ReadEnable, WriteEnable, Address}), 0);
      check("midreset m_data", int'(m_data), 0);
      check("midreset err_code", int'(err_code), 0);
      exp_hold = 0;
      exp_frames = 0;
      exp_errs = 0;
      @(negedge Clk);
      Rst = 1'b1;
      m_ready = 1'b0;
      run_frame(8'h01, 8'd3, 3, 1'b0, 0, 3, "rerun");
    end

    // Table of boundary frames
    foreach (vecs[i]) begin
      for (int k = 0; k < 256; k++) hs_buf[k] = 8'(k * 29 + i * 7 + 3);
      run_frame(vecs[i].status, vecs[i].len, vecs[i].stall, vecs[i].drop_en,
                vecs[i].exp_code, vecs[i].exp_bytes, $sformatf("vec%0d", i));
    end

    // Random frames against the reference outcome
    for (int n = 0; n < 30; n++) begin
      logic [7:0] st, ln;
      int r, code;
      st = 8'h01;
      if ($urandom_range(0, 4) == 0) st = st | 8'(1 << $urandom_range(2, 4));
      if ($urandom_range(0, 1) == 1) st = st | 8'h20;
      r = $urandom_range(0, 9);
      if (r == 0) ln = 8'd0;
      else if (r == 1) ln = 8'($urandom_range(127, 255));
      else ln = 8'($urandom_range(1, 10));
      for (int k = 0; k < 256; k++) hs_buf[k] = 8'($urandom_range(0, 255));
      code = ref_code(st, ln);
      run_frame(st, ln, 1, 1'b0, code, (code == 0) ? int'(ln) : 0, $sformatf("rand%0d", n));
    end

`ifdef HDLC_RX_READER_STATS_EN
    #1;
    check("frame_cnt", int'(frame_cnt), exp_frames);
    check("err_cnt", int'(err_cnt), exp_errs);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
